nios_core_mem_copy_master: RTL and testbench

//  Avalon-MM master that fills or copies a block of 32-bit words in the on-chip memory slave.

---
 rtl/nios_core_mem_copy_master.sv | 142 ++++++++++++++
 tb/tb_nios_core_mem_copy_master.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_core_mem_copy_master.sv
// Avalon-MM block fill/copy master for the on-chip word memory.
// Streams one word per transfer and keeps a running sum of every word written.
module nios_core_mem_copy_master #(
    parameter int unsigned AW           = 10,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW:0]   len,
    input  logic [31:0]   fill_data,
    output logic          busy,
    output logic          done,
    output logic [31:0]   checksum,
    output logic [AW-1:0] m_address,
    output logic [3:0]    m_byteenable,
    output logic          m_chipselect,
    output logic          m_write,
    output logic [31:0]   m_writedata,
    input  logic [31:0]   m_readdata,
    input  logic          m_waitrequest,
    output logic          m_clken
);

    typedef enum logic [2:0] {StIdle, StRd, StRdWait, StWr, StFin} state_e;

    localparam logic [1:0]  LatLast = 2'(READ_LATENCY - 1);
    localparam logic [AW:0] RemOne  = {{AW{1'b0}}, 1'b1};

    state_e        state_q, state_d;
    logic          mode_q, mode_d;
    logic [AW-1:0] src_q, src_d;
    logic [AW-1:0] dst_q, dst_d;
    logic [AW:0]   rem_q, rem_d;
    logic [31:0]   fill_q, fill_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   sum_q, sum_d;
    logic [1:0]    lat_q, lat_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            fill_q  <= '0;
            data_q  <= '0;
            sum_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            fill_q  <= fill_d;
            data_q  <= data_d;
            sum_q   <= sum_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        src_d        = src_q;
        dst_d        = dst_q;
        rem_d        = rem_q;
        fill_d       = fill_q;
        data_d       = data_q;
        sum_d        = sum_q;
        lat_d        = lat_q;
        done         = 1'b0;
        m_chipselect = 1'b0;
        m_write      = 1'b0;
        m_address    = '0;
        m_writedata  = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d = mode;
                    src_d  = src_addr;
                    dst_d  = dst_addr;
                    rem_d  = len;
                    fill_d = fill_data;
                    sum_d  = '0;
                    if (len == '0)  state_d = StFin;
                    else if (mode)  state_d = StWr;
                    else            state_d = StRd;
                end
            end
            StRd: begin
                m_chipselect = 1'b1;
                m_address    = src_q;
                if (!m_waitrequest) begin
                    lat_d   = '0;
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                // Read data is valid in the last of READ_LATENCY wait cycles.
                if (lat_q == LatLast) begin
                    data_d  = m_readdata;
                    state_d = StWr;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            StWr: begin
                m_chipselect = 1'b1;
                m_write      = 1'b1;
                m_address    = dst_q;
                m_writedata  = mode_q ? fill_q : data_q;
                if (!m_waitrequest) begin
                    sum_d = sum_q + m_writedata;
                    src_d = src_q + 1'b1;
                    dst_d = dst_q + 1'b1;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == RemOne) state_d = StFin;
                    else if (mode_q)     state_d = StWr;
                    else                 state_d = StRd;
                end
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy         = (state_q == StRd) || (state_q == StRdWait) || (state_q == StWr);
    assign checksum     = sum_q;
    assign m_byteenable = 4'hF;
    assign m_clken      = 1'b1;

endmodule

// File: tb/tb_nios_core_mem_copy_master.sv
// Bench for nios_core_mem_copy_master: memory slave model plus write scoreboard.
module tb_nios_core_mem_copy_master;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW:0]   len = '0;
    logic [31:0]   fill_data = '0;
    logic          busy, done;
    logic [31:0]   checksum;
    logic [AW-1:0] m_address;
    logic [3:0]    m_byteenable;
    logic          m_chipselect, m_write, m_clken;
    logic [31:0]   m_writedata;
    logic [31:0]   m_readdata = '0;
    logic          m_waitrequest = 1'b0;

    nios_core_mem_copy_master #(.AW(AW), .READ_LATENCY(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .mode         (mode),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .len          (len),
        .fill_data    (fill_data),
        .busy         (busy),
        .done         (done),
        .checksum     (checksum),
        .m_address    (m_address),
        .m_byteenable (m_byteenable),
        .m_chipselect (m_chipselect),
        .m_write      (m_write),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .m_waitrequest(m_waitrequest),
        .m_clken      (m_clken)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;
    wr_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int cs_cnt = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
    int last_wr_cyc = 0, done_cyc = 0;

    // Memory slave with 1-cycle read latency; shares the system reset.
    logic [31:0]   mem [0:(1<<AW)-1];
    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [31:0]   pl_data = '0;
    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (!reset && m_chipselect && !m_waitrequest) begin
            if (m_write) mem[m_address] <= m_writedata;
            else         m_readdata <= mem[m_address];
        end
    end

    // Write scoreboard and stall-stability monitor, sampled mid-cycle.
    logic          stall_prev = 1'b0;
    logic [AW-1:0] prev_addr;
    logic          prev_wr;
    logic [31:0]   prev_wd;
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (m_chipselect) cs_cnt++;
            if (stall_prev) begin
                checks++;
                if (m_address !== prev_addr || m_write !== prev_wr || m_writedata !== prev_wd) begin
                    errors++;
                    $display("FAIL stall_hold: got a=%h w=%b d=%h want a=%h w=%b d=%h",
                             m_address, m_write, m_writedata, prev_addr, prev_wr, prev_wd);
                end
            end
            stall_prev = m_chipselect && m_waitrequest;
            prev_addr  = m_address;
            prev_wr    = m_write;
            prev_wd    = m_writedata;
            if (m_chipselect && !m_write && !m_waitrequest) rd_cnt++;
            if (m_chipselect && m_write && !m_waitrequest) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got a=%h d=%h want none", m_address, m_writedata);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (m_address !== e.addr || m_writedata !== e.data) begin
                        errors++;
                        $display("FAIL write_data: got a=%h d=%h want a=%h d=%h",
                                 m_address, m_writedata, e.addr, e.data);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_we = 1'b0;
    endtask

    task automatic issue(input logic md, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW:0] n, input logic [31:0] fd, output int sc);
        start = 1'b1; mode = md; src_addr = s; dst_addr = d; len = n; fill_data = fd;
        sc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if (done_cnt > d0) ok = 1'b1;
            else tick();
        end
        if (done_cnt > d0) ok = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; mode = 1'b1; len = 11'd4;
        tick(); tick();
        chk("rst_outputs", {busy, done, m_chipselect, m_write, m_byteenable, m_clken},
            {4'b0000, 4'hF, 1'b1});
        chk("rst_checksum", checksum, 32'h0);
        chk("rst_addr_wdata", {22'h0, m_address} | m_writedata, 32'h0);
        reset = 1'b0; start = 1'b0;
        tick();
        chk("start_with_reset_ignored", {busy, m_chipselect}, 32'h0);
    endtask

    task automatic test_fill();
        int s, w0, d0;
        bit ok;
        logic [31:0] sum = '0;
        w0 = wr_cnt; d0 = done_cnt;
        for (int i = 0; i < 4; i++) begin
            wr_t e;
            e.addr = AW'(10'h3FE + i);
            e.data = 32'hA5A5_0001;
            exp_q.push_back(e);
            sum += e.data;
        end
        issue(1'b1, '0, 10'h3FE, 11'd4, 32'hA5A5_0001, s);
        chk("fill_busy", {busy, m_chipselect, m_write}, 32'h7);
        wait_done(d0, 20, ok);
        chk("fill_done_seen", ok, 1);
        chk("fill_last_wr_cyc", last_wr_cyc, s + 4);
        chk("fill_done_cyc", done_cyc, s + 5);
        chk("fill_wr_count", wr_cnt - w0, 4);
        chk("fill_checksum", checksum, sum);
        tick();
        chk("fill_done_pulse", {done, busy}, 32'h0);
        tick(); tick();
        chk("checksum_hold", checksum, sum);
    endtask

    task automatic test_copy();
        int s, d0;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            wr_t e;
            preload(AW'(10'h010 + i), 32'(i + 1));
            preload(AW'(10'h100 + i), 32'hDEAD_BEEF);
            e.addr = AW'(10'h100 + i);
            e.data = 32'(i + 1);
            exp_q.push_back(e);
        end
        d0 = done_cnt;
        issue(1'b0, 10'h010, 10'h100, 11'd3, 32'hFFFF_FFFF, s);
        wait_done(d0, 30, ok);
        chk("copy_done_seen", ok, 1);
        chk("copy_last_wr_cyc", last_wr_cyc, s + 9);
        chk("copy_done_cyc", done_cyc, s + 10);
        chk("copy_checksum", checksum, 32'd6);
        tick();
        for (int i = 0; i < 3; i++) chk("copy_mem", mem[10'h100 + i], 32'(i + 1));
    endtask

    task automatic test_zero_len();
        int s, d0, c0;
        bit ok;
        for (int m = 0; m < 2; m++) begin
            c0 = cs_cnt; d0 = done_cnt;
            issue(m[0], 10'h005, 10'h006, 11'd0, 32'h1234_5678, s);
            wait_done(d0, 10, ok);
            chk("zero_done_seen", ok, 1);
            chk("zero_done_cyc", done_cyc, s + 1);
            chk("zero_no_chipselect", cs_cnt - c0, 0);
            chk("zero_checksum", checksum, 32'h0);
            tick();
        end
    endtask

    task automatic test_stall();
        int s, d0, base_rd, base_wr, st_rd, st_wr;
        wr_t e;
        preload(10'h020, 32'h1111_1111);
        preload(10'h021, 32'h2222_2222);
        e.addr = 10'h200; e.data = 32'h1111_1111; exp_q.push_back(e);
        e.addr = 10'h201; e.data = 32'h2222_2222; exp_q.push_back(e);
        base_rd = rd_cnt; base_wr = wr_cnt; d0 = done_cnt; st_rd = 0; st_wr = 0;
        issue(1'b0, 10'h020, 10'h200, 11'd2, '0, s);
        for (int i = 0; i < 40 && done_cnt == d0; i++) begin
            m_waitrequest = 1'b0;
            if (m_chipselect && !m_write && rd_cnt == base_rd && st_rd < 3) begin
                m_waitrequest = 1'b1; st_rd++;
            end else if (m_chipselect && m_write && wr_cnt == base_wr + 1 && st_wr < 2) begin
                m_waitrequest = 1'b1; st_wr++;
            end
            tick();
        end
        m_waitrequest = 1'b0;
        chk("stall_done_seen", done_cnt, d0 + 1);
        chk("stall_done_cyc", done_cyc, s + 12);
        chk("stall_checksum", checksum, 32'h3333_3333);
        tick();
    endtask

    task automatic test_reset_mid();
        int s, d0;
        wr_t e;
        for (int i = 0; i < 5; i++) preload(AW'(10'h040 + i), 32'hCAFE_0000);
        for (int i = 0; i < 2; i++) begin
            e.addr = AW'(10'h040 + i); e.data = 32'h0BAD_F00D; exp_q.push_back(e);
        end
        d0 = done_cnt;
        issue(1'b1, '0, 10'h040, 11'd5, 32'h0BAD_F00D, s);
        tick(); tick();
        chk("mid_in_word2", {22'h0, m_address}, 32'h042);
        reset = 1'b1;
        tick();
        chk("mid_after_reset", {m_chipselect, busy, done}, 32'h0);
        chk("mid_checksum", checksum, 32'h0);
        reset = 1'b0;
        repeat (6) tick();
        chk("mid_no_done", done_cnt, d0);
        chk("mid_word1", mem[10'h041], 32'h0BAD_F00D);
        chk("mid_word2_untouched", mem[10'h042], 32'hCAFE_0000);
    endtask

    task automatic test_back_to_back();
        int s, s2, d0;
        bit ok;
        wr_t e;
        preload(10'h300, 32'h5A5A_5A5A);
        for (int i = 0; i < 3; i++) begin
            e.addr = AW'(10'h180 + i); e.data = 32'(i + 1); exp_q.push_back(e);
        end
        d0 = done_cnt;
        issue(1'b0, 10'h010, 10'h180, 11'd3, '0, s);
        tick();
        issue(1'b1, '0, 10'h300, 11'd5, 32'h7777_7777, s2);
        wait_done(d0, 30, ok);
        chk("b2b_done_seen", ok, 1);
        repeat (12) tick();
        chk("b2b_single_done", done_cnt, d0 + 1);
        chk("b2b_checksum", checksum, 32'd6);
        chk("b2b_fill_ignored", mem[10'h300], 32'h5A5A_5A5A);
        chk("b2b_idle", {busy, m_chipselect}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_copy();
        test_zero_len();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
